// File: rtl/pipelined_add_sub.sv
// Carry-pipelined adder/subtractor. Each stage resolves one SEG-bit slice and
// hands its carry to the next stage; a valid/ready handshake with bubble
// collapse runs alongside the data.
//
// The A operand and the result share one rotating "ring" register per stage:
// a stage consumes the lowest SEG bits (its A slice) and inserts its sum slice
// at the top. After STAGES rotations the ring holds the aligned result. The
// inverted-or-not B operand travels in a separate skew register holding only
// the slices still to be consumed.
module pipelined_add_sub #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int OPS    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int OPW    = (WIDTH > SEG) ? WIDTH - SEG : 1;

  // Control
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] en;

  // Intermediate stage data (stages 0..STAGES-2)
  logic [WIDTH-1:0]  ring_q [OPS];
  logic [OPW-1:0]    bx_q   [OPS];
  logic              c_q    [OPS];

  // Next-state data per stage
  logic [WIDTH-1:0]  ring_d [STAGES];
  logic [OPW-1:0]    bx_d   [OPS];
  logic              c_d    [STAGES];
  logic              cmsb;

  // Final-stage (output) registers
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] r_in;
    logic [SEG-1:0]   b_sl;
    logic             c_in;
    logic [SEG:0]     add_w;

    if (k == 0) begin : g_first
      assign r_in    = a;
      assign b_sl    = b[SEG-1:0] ^ {SEG{sub}};
      assign c_in    = cin ^ sub;
      assign v_in[k] = in_valid;
    end else begin : g_next
      assign r_in    = ring_q[k-1];
      assign b_sl    = bx_q[k-1][SEG-1:0];
      assign c_in    = c_q[k-1];
      assign v_in[k] = vld_q[k-1];
    end

    assign add_w = {1'b0, r_in[SEG-1:0]} + {1'b0, b_sl} + {{SEG{1'b0}}, c_in};
    assign c_d[k] = add_w[SEG];

    if (STAGES == 1) begin : g_single
      assign ring_d[k] = add_w[SEG-1:0];
    end else begin : g_rot
      assign ring_d[k] = {add_w[SEG-1:0], r_in[WIDTH-1:SEG]};
    end

    if (k < STAGES - 1) begin : g_skew
      if (k == 0) begin : g_bx0
        assign bx_d[k] = b[WIDTH-1:SEG] ^ {OPW{sub}};
      end else begin : g_bxn
        assign bx_d[k] = {{SEG{1'b0}}, bx_q[k-1][OPW-1:SEG]};
      end
    end else begin : g_last
      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
      assign cmsb = r_in[SEG-1] ^ b_sl[SEG-1] ^ add_w[SEG-1];
    end

    assign en[k] = ld[k] & v_in[k];
  end

  // Load enables: a stage loads when empty or when its successor loads.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = !vld_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = !vld_q[k] || ld[k+1];
    end
  end

  // Valid flags advance with each stage load; reset empties the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) vld_q[k] <= v_in[k];
      end
    end
  end

  // Intermediate data registers; loaded only when a real beat enters.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (en[k]) begin
        ring_q[k] <= ring_d[k];
        bx_q[k]   <= bx_d[k];
        c_q[k]    <= c_d[k];
      end
    end
  end

  // Final stage: aligned result, carry-out and signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (en[STAGES-1]) begin
      sum_q  <= ring_d[STAGES-1];
      cout_q <= c_d[STAGES-1];
      ovf_q  <= cmsb ^ c_d[STAGES-1];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[STAGES-1];
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub at WIDTH=8, SEG=4 (two stages).
module tb_pipelined_add_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  pipelined_add_sub #(.WIDTH(8), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Hand-computed vectors: a, b, cin, sub -> sum, cout, ovf
  logic [7:0] va [10] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10, 8'h12, 8'h80, 8'h00, 8'h00, 8'hFF};
  logic [7:0] vb [10] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h03, 8'h34, 8'h80, 8'h00, 8'h01, 8'hFF};
  logic       vc [10] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic       vs [10] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [7:0] es [10] = '{8'h00, 8'h80, 8'hFE, 8'h7F, 8'h0C, 8'h47, 8'h00, 8'h00, 8'hFE, 8'hFF};
  logic       ec [10] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
  logic       eo [10] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

  logic [10:0] q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_of(input int i);
    return {1'b1, ec[i], eo[i], es[i]};
  endfunction

  function automatic logic [10:0] obs_out();
    return {out_valid, cout, ovf, sum};
  endfunction

  task automatic drive(input int i, input logic v);
    a        = va[i];
    b        = vb[i];
    cin      = vc[i];
    sub      = vs[i];
    in_valid = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    // Reset state
    check("reset_out", {21'd0, obs_out()}, 32'h0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beats with two-cycle visibility
    for (int i = 0; i < 10; i++) begin
      drive(i, 1'b1);
      step();
      in_valid = 1'b0;
      check($sformatf("single_mid_%0d", i), {31'd0, out_valid}, 32'd0);
      step();
      check($sformatf("single_%0d", i), {21'd0, obs_out()}, {21'd0, exp_of(i)});
      step();
      check($sformatf("single_drained_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Streaming back-to-back, mixed add/sub per beat
    for (int i = 0; i < 10; i++) begin
      drive(i, 1'b1);
      #1;
      check($sformatf("stream_ready_%0d", i), {31'd0, in_ready}, 32'd1);
      step();
      if (i > 0) check($sformatf("stream_%0d", i - 1), {21'd0, obs_out()}, {21'd0, exp_of(i - 1)});
    end
    in_valid = 1'b0;
    step();
    check("stream_9", {21'd0, obs_out()}, {21'd0, exp_of(9)});
    step();
    check("stream_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: exactly two beats fit, output holds while stalled
    out_ready = 1'b0;
    drive(3, 1'b1);
    step();
    drive(4, 1'b1);
    #1;
    check("bp_ready_second", {31'd0, in_ready}, 32'd1);
    step();
    drive(5, 1'b1);
    #1;
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_0", {21'd0, obs_out()}, {21'd0, exp_of(3)});
    step(); step();
    check("bp_hold_1", {21'd0, obs_out()}, {21'd0, exp_of(3)});
    check("bp_full_ready_1", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_push_pop_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_drain_0", {21'd0, obs_out()}, {21'd0, exp_of(4)});
    step();
    check("bp_drain_1", {21'd0, obs_out()}, {21'd0, exp_of(5)});
    step();
    check("bp_drain_done", {31'd0, out_valid}, 32'd0);

    // Patterned stalls with a scoreboard of table results
    pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      drive(pushed % 10, (c % 3) != 2 && (c % 7) != 4);
      out_ready = ((c / 2) % 3) != 0;
      #1;
      if (out_valid && out_ready && in_valid)
        check("stall_push_pop_ready", {31'd0, in_ready}, 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("stall_unexpected_out", {31'd0, out_valid}, 32'd0);
        else check("stall_result", {21'd0, obs_out()}, {21'd0, q.pop_front()});
      end
      if (in_valid && in_ready) begin
        q.push_back(exp_of(pushed % 10));
        pushed++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("drain_unexpected_out", {31'd0, out_valid}, 32'd0);
        else check("drain_result", {21'd0, obs_out()}, {21'd0, q.pop_front()});
      end
      step();
    end
    check("stall_queue_empty", q.size(), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    drive(0, 1'b1);
    step();
    drive(1, 1'b1);
    step();
    in_valid = 1'b0;
    check("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_out", {21'd0, obs_out()}, 32'h0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("rst_no_stale_%0d", c), {31'd0, out_valid}, 32'd0);
    end
    drive(8, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("rst_after_beat", {21'd0, obs_out()}, {21'd0, exp_of(8)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
